// File: rtl/bits_to_bcd_pkg.sv
// Purpose : shared types, constants and the BCD digit correction helper.
// Latency : n/a (declarations and a pure combinational function only).
// Backpres: n/a.
package bits_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Double-dabble correction: a digit of 5 or more would become >= 10 after
    // the next left shift, so pre-add 3 to make it carry into the next digit.
    function automatic logic [BCD_DIGIT_W-1:0] add3_if_ge5(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/bits_to_bcd_if.sv
// Purpose : start/done handshake and data bundle of the binary-to-BCD converter.
// Latency : n/a (wires only).
// Backpres: start is only honoured while busy is low; nothing is queued.
// Ports   : start/b driven by the requester, busy/done/bcd/d driven by the converter.
interface bits_to_bcd_if #(
    parameter int W      = 4,
    parameter int DIGITS = 2
);
    import bits_to_bcd_pkg::*;

    logic                          start;
    logic [W-1:0]                  b;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic [BCD_DIGIT_W-1:0]        d;

    modport master (output start, b, input busy, done, bcd, d);
    modport slave  (input start, b, output busy, done, bcd, d);

endinterface

// File: rtl/bcd_digit_adj.sv
// Purpose : single BCD digit corrector, adds 3 when the digit is 5 or more.
// Latency : combinational, zero cycles.
// Backpres: none.
// Ports   : i_digit - 4-bit scratch digit in, o_digit - corrected digit out.
module bcd_digit_adj
    import bits_to_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = add3_if_ge5(i_digit);

endmodule

// File: rtl/bits_to_bcd.sv
// Purpose : sequential binary-to-BCD converter (shift-and-add-3), one conversion at a time.
// Latency : W+1 cycles from accepted start to the done pulse; one conversion per W+2 cycles.
// Backpres: start is ignored (not queued) while busy; results held until the next conversion ends.
// Ports   : clk, rst_n (async active-low), io - slave side of bits_to_bcd_if.
module bits_to_bcd
    import bits_to_bcd_pkg::*;
#(
    parameter int W      = 4,
    parameter int DIGITS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    bits_to_bcd_if.slave  io
);

    localparam int SW    = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    state_t           r_state;
    logic [W-1:0]     r_bin;
    logic [SW-1:0]    r_scratch;
    logic [CNT_W-1:0] r_cnt;
    logic [SW-1:0]    r_bcd;
    logic             r_done;

    logic [SW-1:0]    w_adj;
    logic [SW+W-1:0]  w_shl;

    // Per-digit correction of the scratch register before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Shift {corrected scratch, binary} left by one; the bit leaving the
    // scratch MSB is always zero when DIGITS is sized for W, so it is dropped.
    assign w_shl = {w_adj, r_bin} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (io.start) begin
                        r_bin     <= io.b;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(W);
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_shl[SW+W-1:W];
                    r_bin     <= w_shl[W-1:0];
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Only completed results ever reach the output register.
                    r_bcd   <= r_scratch;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io.busy = (r_state != IDLE);
    assign io.done = r_done;
    assign io.bcd  = r_bcd;
    assign io.d    = r_bcd[BCD_DIGIT_W-1:0];

endmodule

// File: tb/tb_bits_to_bcd.sv
// Purpose : scoreboard bench for bits_to_bcd at W=4/DIGITS=2 and W=8/DIGITS=3.
// Latency : checks done arrives exactly W+1 cycles after the accepting edge.
// Backpres: drives start only when idle, except where ignore-while-busy is exercised.
module tb_bits_to_bcd;

    typedef struct {
        logic [11:0] bcd;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   errs;
    exp_t q4[$];
    exp_t q8[$];
    logic prev4;
    logic prev8;
    logic [7:0] tab [16];

    bits_to_bcd_if #(.W(4), .DIGITS(2)) if4 ();
    bits_to_bcd_if #(.W(8), .DIGITS(3)) if8 ();

    bits_to_bcd #(.W(4), .DIGITS(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .io(if4));
    bits_to_bcd #(.W(8), .DIGITS(3)) u_dut8 (.clk(clk), .rst_n(rst_n), .io(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitors: pop the expected result whenever a done pulse is presented.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n && if4.done) begin
            check("done4_single_pulse", 32'(prev4), 32'd0);
            if (q4.size() == 0) begin
                tests++;
                errs++;
                $display("FAIL done4_unexpected: got done with bcd %0h, expected no done", if4.bcd);
            end else begin
                e = q4.pop_front();
                check("bcd4", 32'(if4.bcd), 32'(e.bcd));
                check("d4", 32'(if4.d), 32'(e.bcd[3:0]));
                check("latency4", 32'(cyc - e.acc), 32'd5);
            end
        end
        prev4 = if4.done;
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && if8.done) begin
            check("done8_single_pulse", 32'(prev8), 32'd0);
            if (q8.size() == 0) begin
                tests++;
                errs++;
                $display("FAIL done8_unexpected: got done with bcd %0h, expected no done", if8.bcd);
            end else begin
                e = q8.pop_front();
                check("bcd8", 32'(if8.bcd), 32'(e.bcd));
                check("d8", 32'(if8.d), 32'(e.bcd[3:0]));
                check("latency8", 32'(cyc - e.acc), 32'd9);
            end
        end
        prev8 = if8.done;
    end

    // Issue one start pulse; the accepting edge is the next rising edge.
    task automatic conv4(input int v, input logic [11:0] exp_bcd, input bit expect_accept);
        @(negedge clk);
        if4.b     = v[3:0];
        if4.start = 1'b1;
        if (expect_accept) q4.push_back('{bcd: exp_bcd, acc: cyc + 1});
        @(negedge clk);
        if4.start = 1'b0;
        check("busy4_after_start", 32'(if4.busy), 32'd1);
    endtask

    task automatic conv8(input int v, input logic [11:0] exp_bcd);
        @(negedge clk);
        if8.b     = v[7:0];
        if8.start = 1'b1;
        q8.push_back('{bcd: exp_bcd, acc: cyc + 1});
        @(negedge clk);
        if8.start = 1'b0;
        check("busy8_after_start", 32'(if8.busy), 32'd1);
    endtask

    task automatic wait_idle4();
        int n;
        n = 0;
        while ((if4.busy || if4.done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle4_within_budget", 32'(n < 40), 32'd1);
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        while ((if8.busy || if8.done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle8_within_budget", 32'(n < 40), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        tests = 0;
        errs  = 0;
        prev4 = 1'b0;
        prev8 = 1'b0;
        tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

        // Reset held with start asserted: nothing may start.
        rst_n     = 1'b0;
        if4.start = 1'b1;
        if4.b     = 4'd5;
        if8.start = 1'b1;
        if8.b     = 8'd5;
        repeat (3) @(negedge clk);
        check("rst_busy4", 32'(if4.busy), 32'd0);
        check("rst_done4", 32'(if4.done), 32'd0);
        check("rst_bcd4", 32'(if4.bcd), 32'd0);
        check("rst_d4", 32'(if4.d), 32'd0);
        check("rst_busy8", 32'(if8.busy), 32'd0);
        check("rst_bcd8", 32'(if8.bcd), 32'd0);
        if4.start = 1'b0;
        if8.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_rst_busy4", 32'(if4.busy), 32'd0);

        // Full 4-bit sweep.
        for (int v = 0; v < 16; v++) begin
            conv4(v, {4'h0, tab[v]}, 1'b1);
            wait_idle4();
        end

        // Out-of-range integers wrap onto the 4-bit operand.
        conv4(16, 12'h000, 1'b1); wait_idle4();
        conv4(17, 12'h001, 1'b1); wait_idle4();
        conv4(18, 12'h002, 1'b1); wait_idle4();
        conv4(19, 12'h003, 1'b1); wait_idle4();

        // start held high: re-accepted on the first idle edge, W+2 cycles later.
        @(negedge clk);
        if4.b     = 4'd7;
        if4.start = 1'b1;
        q4.push_back('{bcd: 12'h007, acc: cyc + 1});
        q4.push_back('{bcd: 12'h007, acc: cyc + 7});
        repeat (7) @(negedge clk);
        if4.start = 1'b0;
        wait_idle4();
        check("b2b_queue_drained", 32'(q4.size()), 32'd0);

        // start while busy is ignored: only the b=9 conversion completes.
        conv4(9, 12'h009, 1'b1);
        @(negedge clk);
        if4.b     = 4'd3;
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        wait_idle4();
        repeat (8) @(negedge clk);
        check("ignore_queue_drained", 32'(q4.size()), 32'd0);
        check("ignore_bcd4", 32'(if4.bcd), 32'h09);

        // Reset mid-conversion aborts it without a done pulse.
        conv4(15, 12'h015, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        q4.delete();
        #1;
        check("abort_bcd4", 32'(if4.bcd), 32'd0);
        check("abort_d4", 32'(if4.d), 32'd0);
        check("abort_busy4", 32'(if4.busy), 32'd0);
        check("abort_done4", 32'(if4.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        conv4(15, 12'h015, 1'b1);
        wait_idle4();

        // Wider instance: W=8, DIGITS=3.
        conv8(255, 12'h255); wait_idle8();
        conv8(0,   12'h000); wait_idle8();
        conv8(100, 12'h100); wait_idle8();
        conv8(99,  12'h099); wait_idle8();

        repeat (4) @(negedge clk);
        check("final_q4_empty", 32'(q4.size()), 32'd0);
        check("final_q8_empty", 32'(q8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
